// File: rtl/scl_phase_sequencer.sv
// scl_phase_sequencer: drives SCL through START, nbits x (LOW, HIGH), STOP using an external down-counter.
// Optional feature macro I3C_SCL_STRETCH_EN: wait for scl_i high before timing each HIGH phase.
module scl_phase_sequencer #(
  parameter int CNTR_W  = 9,
  parameter int NBITS_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  output logic               ready_o,
  input  logic [NBITS_W-1:0] nbits_i,
  input  logic [CNTR_W-1:0]  t_start_i,
  input  logic [CNTR_W-1:0]  t_low_i,
  input  logic [CNTR_W-1:0]  t_high_i,
  input  logic [CNTR_W-1:0]  t_stop_i,
  input  logic               abort_i,
  output logic               cnt_load_o,
  output logic [CNTR_W-1:0]  cnt_init_o,
  input  logic               cnt_q_i,
  input  logic               scl_i,
  output logic               scl_o,
  output logic               bit_rise_o,
  output logic               bit_fall_o,
  output logic               done_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOW, S_HIGH, S_STOP} state_t;

  state_t             state;
  logic [NBITS_W-1:0] bits_left;
  logic [CNTR_W-1:0]  t_low_r;
  logic [CNTR_W-1:0]  t_high_r;
  logic [CNTR_W-1:0]  t_stop_r;
  logic               load_r;
  logic               rise_r;
  logic               stretch_wait;
  logic               release_now;
  logic               phase_end;

`ifdef I3C_SCL_STRETCH_EN
  // scl_i arrives already synchronised; the cycle it is seen high becomes the HIGH entry cycle.
  assign release_now = stretch_wait & scl_i;
`else
  logic unused_scl;
  assign unused_scl  = scl_i;
  assign release_now = 1'b0;
`endif

  assign cnt_load_o = load_r | release_now;
  assign bit_rise_o = rise_r | release_now;

  // The zero flag is stale while the counter is being loaded, and meaningless during a stretch wait.
  assign phase_end = cnt_q_i & ~cnt_load_o & ~stretch_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      bits_left    <= '0;
      t_low_r      <= '0;
      t_high_r     <= '0;
      t_stop_r     <= '0;
      load_r       <= 1'b0;
      rise_r       <= 1'b0;
      stretch_wait <= 1'b0;
      cnt_init_o   <= '0;
      scl_o        <= 1'b1;
      ready_o      <= 1'b1;
      busy_o       <= 1'b0;
      bit_fall_o   <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      // NOTE: pulses default low here with non-blocking writes; a later write in the same cycle overrides.
      load_r     <= 1'b0;
      rise_r     <= 1'b0;
      bit_fall_o <= 1'b0;
      done_o     <= 1'b0;

      if (state != S_IDLE && abort_i) begin
        state        <= S_IDLE;
        bits_left    <= '0;
        stretch_wait <= 1'b0;
        scl_o        <= 1'b1;
        ready_o      <= 1'b1;
        busy_o       <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (req_i) begin
              bits_left  <= nbits_i;
              t_low_r    <= t_low_i;
              t_high_r   <= t_high_i;
              t_stop_r   <= t_stop_i;
              state      <= S_START;
              scl_o      <= 1'b1;
              load_r     <= 1'b1;
              cnt_init_o <= t_start_i;
              ready_o    <= 1'b0;
              busy_o     <= 1'b1;
            end
          end

          S_START: begin
            if (phase_end) begin
              if (bits_left != '0) begin
                state      <= S_LOW;
                scl_o      <= 1'b0;
                load_r     <= 1'b1;
                bit_fall_o <= 1'b1;
                cnt_init_o <= t_low_r;
              end else begin
                state      <= S_STOP;
                scl_o      <= 1'b1;
                load_r     <= 1'b1;
                cnt_init_o <= t_stop_r;
              end
            end
          end

          S_LOW: begin
            if (phase_end) begin
              state      <= S_HIGH;
              scl_o      <= 1'b1;
              cnt_init_o <= t_high_r;
`ifdef I3C_SCL_STRETCH_EN
              stretch_wait <= 1'b1;
`else
              load_r <= 1'b1;
              rise_r <= 1'b1;
`endif
            end
          end

          S_HIGH: begin
            if (stretch_wait) begin
              if (release_now) stretch_wait <= 1'b0;
            end else if (phase_end) begin
              bits_left <= bits_left - NBITS_W'(1);
              if (bits_left > NBITS_W'(1)) begin
                state      <= S_LOW;
                scl_o      <= 1'b0;
                load_r     <= 1'b1;
                bit_fall_o <= 1'b1;
                cnt_init_o <= t_low_r;
              end else begin
                state      <= S_STOP;
                scl_o      <= 1'b1;
                load_r     <= 1'b1;
                cnt_init_o <= t_stop_r;
              end
            end
          end

          S_STOP: begin
            if (phase_end) begin
              state   <= S_IDLE;
              done_o  <= 1'b1;
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scl_phase_sequencer.sv
// Scoreboard bench for scl_phase_sequencer: each request pushes its expected per-cycle waveform,
// a negedge monitor pops and compares one record per cycle (idle expected when the queue is empty).
module tb_scl_phase_sequencer;
  localparam int CNTR_W  = 9;
  localparam int NBITS_W = 5;

  typedef struct packed {
    logic              scl;
    logic              load;
    logic [CNTR_W-1:0] init;
    logic              rise;
    logic              fall;
    logic              busy;
    logic              ready;
    logic              done;
  } obs_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               req = 1'b0;
  logic               ready_o;
  logic [NBITS_W-1:0] nbits = '0;
  logic [CNTR_W-1:0]  t_start = '0;
  logic [CNTR_W-1:0]  t_low = '0;
  logic [CNTR_W-1:0]  t_high = '0;
  logic [CNTR_W-1:0]  t_stop = '0;
  logic               abort = 1'b0;
  logic               cnt_load_o;
  logic [CNTR_W-1:0]  cnt_init_o;
  logic               cnt_q;
  logic               scl_in = 1'b1;
  logic               scl_o;
  logic               bit_rise_o;
  logic               bit_fall_o;
  logic               done_o;
  logic               busy_o;

  scl_phase_sequencer #(.CNTR_W(CNTR_W), .NBITS_W(NBITS_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .ready_o   (ready_o),
    .nbits_i   (nbits),
    .t_start_i (t_start),
    .t_low_i   (t_low),
    .t_high_i  (t_high),
    .t_stop_i  (t_stop),
    .abort_i   (abort),
    .cnt_load_o(cnt_load_o),
    .cnt_init_o(cnt_init_o),
    .cnt_q_i   (cnt_q),
    .scl_i     (scl_in),
    .scl_o     (scl_o),
    .bit_rise_o(bit_rise_o),
    .bit_fall_o(bit_fall_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  // Counter model holds at zero, so the stale flag is high on every phase entry and throughout idle.
  logic [CNTR_W-1:0] cnt = '0;
  always @(posedge clk) begin
    if (cnt_load_o)      cnt <= cnt_init_o;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end
  assign cnt_q = (cnt == '0);

  obs_t exp_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  int   done_cnt = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic obs_t idle_rec(input logic done);
    obs_t r;
    r = '{scl:1'b1, load:1'b0, init:'0, rise:1'b0, fall:1'b0, busy:1'b0, ready:1'b1, done:done};
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r = '{scl:scl_o, load:cnt_load_o, init:(cnt_load_o ? cnt_init_o : '0), rise:bit_rise_o,
          fall:bit_fall_o, busy:busy_o, ready:ready_o, done:done_o};
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      obs_t o;
      obs_t e;
      o = sample();
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = idle_rec(1'b0);
      rise_cnt += int'(bit_rise_o);
      fall_cnt += int'(bit_fall_o);
      done_cnt += int'(done_o);
      check($sformatf("cycle %0d", cyc), 32'(o), 32'(e));
      cyc++;
    end
  end

  task automatic push_phase(input logic scl, input int v, input logic rise, input logic fall);
    for (int c = 0; c < v + 2; c++) begin
      obs_t r;
      r = '{scl:scl, load:(c == 0), init:((c == 0) ? CNTR_W'(v) : '0), rise:(rise && c == 0),
            fall:(fall && c == 0), busy:1'b1, ready:1'b0, done:1'b0};
      exp_q.push_back(r);
    end
  endtask

  task automatic push_xfer(input int ts, input int tl, input int th, input int tp, input int nb);
    push_phase(1'b1, ts, 1'b0, 1'b0);
    for (int b = 0; b < nb; b++) begin
      push_phase(1'b0, tl, 1'b0, 1'b1);
      push_phase(1'b1, th, 1'b1, 1'b0);
    end
    push_phase(1'b1, tp, 1'b0, 1'b0);
    exp_q.push_back(idle_rec(1'b1));
  endtask

  // Drives a request just after a sampling edge; the next rising edge accepts it.
  task automatic start_xfer(input int ts, input int tl, input int th, input int tp, input int nb);
    @(negedge clk); #1;
    rise_cnt = 0; fall_cnt = 0; done_cnt = 0;
    t_start = CNTR_W'(ts); t_low = CNTR_W'(tl); t_high = CNTR_W'(th); t_stop = CNTR_W'(tp);
    nbits = NBITS_W'(nb);
    req = 1'b1;
    push_xfer(ts, tl, th, tp, nb);
  endtask

  task automatic release_and_scramble();
    @(posedge clk); #1;
    req = 1'b0;
    t_start = '1; t_low = '1; t_high = '1; t_stop = '1; nbits = '1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(posedge clk);
    check({tag, " drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset outputs", 32'(sample()), 32'(idle_rec(1'b0)));
    check("reset cnt_init", 32'(cnt_init_o), 32'd0);
    #19 rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);

    // Single transfer, inputs scrambled after capture.
    start_xfer(3, 4, 2, 3, 2);
    release_and_scramble();
    drain("single");
    check("single rises", 32'(rise_cnt), 32'd2);
    check("single falls", 32'(fall_cnt), 32'd2);
    check("single done", 32'(done_cnt), 32'd1);

    // nbits = 0: START then STOP only.
    start_xfer(1, 5, 5, 1, 0);
    release_and_scramble();
    drain("nbits0");
    check("nbits0 strobes", 32'(rise_cnt + fall_cnt), 32'd0);
    check("nbits0 done", 32'(done_cnt), 32'd1);

    // All durations zero: every phase two cycles.
    start_xfer(0, 0, 0, 0, 3);
    release_and_scramble();
    drain("zero");
    check("zero rises", 32'(rise_cnt), 32'd3);

    // Abort in the second cycle of the second LOW phase (cycle 17 after accept).
    start_xfer(3, 4, 2, 3, 2);
    while (exp_q.size() > 17) void'(exp_q.pop_back());
    release_and_scramble();
    repeat (16) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    drain("abort");
    check("abort falls", 32'(fall_cnt), 32'd2);
    check("abort done", 32'(done_cnt), 32'd0);

    // Abort while idle has no effect; a fresh request runs normally.
    @(negedge clk); #1 abort = 1'b1;
    repeat (2) @(posedge clk);
    #1 abort = 1'b0;
    start_xfer(1, 1, 1, 1, 1);
    release_and_scramble();
    drain("post-abort");
    check("post-abort done", 32'(done_cnt), 32'd1);

    // Back-to-back: req held through the done cycle; 30 phase cycles per transfer.
    start_xfer(3, 4, 2, 3, 2);
    push_xfer(3, 4, 2, 3, 2);
    repeat (32) @(posedge clk);
    #1 req = 1'b0;
    drain("b2b");
    check("b2b rises", 32'(rise_cnt), 32'd4);
    check("b2b done", 32'(done_cnt), 32'd2);

    // Asynchronous reset mid-transfer.
    start_xfer(2, 2, 2, 2, 4);
    release_and_scramble();
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset outputs", 32'(sample()), 32'(idle_rec(1'b0)));
    check("midreset cnt_init", 32'(cnt_init_o), 32'd0);
    done_cnt = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("midreset done", 32'(done_cnt), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scl_phase_sequencer.md
Name: scl_phase_sequencer

Overview:
- Upstream/downstream partner of the I3C controller's down-counter (load / init_value / zero-flag q).
- Sequences SCL phases for one transfer: START hold, nbits × (LOW, HIGH), STOP hold.
- For each phase it loads the counter with the programmed duration and advances when the counter reports zero.
- Drives SCL level and per-bit strobes toward the controller's bit-level FSM.

Parameters:
- CNTR_W, 9: width of the counter init value and timing inputs; must match the counter.
- NBITS_W, 5: width of the bit-count request.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_i  input  1  transfer request; accepted when req_i && ready_o
- ready_o  output  1  high only in IDLE
- nbits_i  input  NBITS_W  number of SCL clocks in the transfer; captured at accept
- t_start_i  input  CNTR_W  START hold duration code
- t_low_i  input  CNTR_W  SCL low duration code
- t_high_i  input  CNTR_W  SCL high duration code
- t_stop_i  input  CNTR_W  STOP hold duration code
- abort_i  input  1  synchronous abort
- cnt_load_o  output  1  counter load strobe
- cnt_init_o  output  CNTR_W  counter init value
- cnt_q_i  input  1  counter zero flag
- scl_i  input  1  sampled bus SCL; used only with the optional feature
- scl_o  output  1  SCL drive level (1 = released/high)
- bit_rise_o  output  1  1-cycle pulse on the first cycle of each HIGH phase
- bit_fall_o  output  1  1-cycle pulse on the first cycle of each LOW phase
- done_o  output  1  1-cycle pulse when STOP completes
- busy_o  output  1  high when not IDLE

Behaviour:
- Reset values:
  - State = IDLE.
  - scl_o=1, ready_o=1, busy_o=0, cnt_load_o=0, cnt_init_o=0.
  - bit_rise_o=0, bit_fall_o=0, done_o=0.
- All outputs are registered.
- States: IDLE, START, LOW, HIGH, STOP.
- Accept: in IDLE, req_i=1 captures nbits_i and all four t_*_i, then moves to START. Timing inputs are ignored after capture.
- Phase entry: in the first cycle of every phase, cnt_load_o=1 and cnt_init_o = the captured duration for that phase. cnt_load_o=0 in all other cycles.
- Phase exit:
  - cnt_q_i is ignored in the entry cycle, because it reflects the stale count.
  - From the second cycle on, cnt_q_i=1 ends the phase at that clock edge.
  - A phase with duration V therefore lasts exactly V+2 cycles.
  - V=0 is legal and gives a 2-cycle phase.
- Transitions:
  - START → LOW if the remaining bit count > 0, else → STOP.
  - LOW → HIGH.
  - HIGH: decrement the remaining bit count; → LOW if the count was > 1, else → STOP.
  - STOP → IDLE; done_o pulses in the first IDLE cycle.
- scl_o per state: 0 in LOW; 1 in IDLE, START, HIGH and STOP.
- bit_fall_o / bit_rise_o: one pulse per LOW / HIGH entry, coincident with cnt_load_o. Total per transfer = nbits.
- nbits=0: sequence is START then STOP; no LOW/HIGH phases, no bit strobes.
- Back-to-back: a req_i held in the done_o cycle is accepted in that cycle (ready_o=1), so there is no idle gap beyond one cycle.
- abort_i:
  - Takes priority over all other events in any non-IDLE state.
  - Next cycle: state = IDLE, scl_o=1, no done_o, remaining count cleared.
  - Ignored in IDLE.
- cnt_q_i while IDLE (free-running counter wraps) is ignored.
- Asynchronous reset mid-transfer immediately forces all reset values; no done_o is issued.

Optional Feature:
- Macro: I3C_SCL_STRETCH_EN.
- Defined:
  - On HIGH entry the FSM first waits with scl_o=1 and no counter load until scl_i=1 (target/peer stretch).
  - The first cycle with scl_i=1 is the phase entry cycle: cnt_load_o and bit_rise_o fire there.
  - HIGH length = stretch cycles + V+2.
  - abort_i still exits the wait.
- Undefined: scl_i is ignored; HIGH entry loads immediately.

Test Plan:
- Single transfer: t_start=3, t_low=4, t_high=2, t_stop=3, nbits=2 → phases of 5,6,4,6,4,5 cycles; scl_o = 1(5),0(6),1(4),0(6),1(4),1(5); done_o pulses once; 2 rises and 2 falls.
- nbits=0, t_start=1, t_stop=1 → 3+3 cycles busy, scl_o stays 1, no bit strobes, done_o at cycle 7 after accept.
- Zero durations, nbits=3, all t=0 → every phase 2 cycles, cnt_load_o every second cycle, total 16 cycles START→done.
- abort_i in the 2nd cycle of the second LOW phase → next cycle IDLE, scl_o=1, ready_o=1, no done_o; a new req is accepted normally afterward.
- Back-to-back: req_i held high through done_o → second transfer accepted in the done_o cycle and produces an identical waveform.
- I3C_SCL_STRETCH_EN defined, scl_i held low 7 cycles after HIGH entry, t_high=2 → scl_o=1 for 7+4 cycles; bit_rise_o fires on the first cycle with scl_i=1.
